// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_unit
//  Description : Control FSM for a multicycle MIPS-like datapath. It decodes
//                op/func from the instruction register, sequences the
//                IF/ID/EXE/MEM/WB states, and drives the datapath strobes and
//                mux selects.
//  Ports       : CLK, Reset         - clock, synchronous active-high reset
//                op, func           - opcode / function fields from the IR
//                zero, sign         - ALU flags, used only in sEXE_BR
//                mem_ready          - data memory completion handshake
//                PCWre, IRWre,
//                RegWre, mRD, mWR   - write/read strobes
//                ExtSel, DBDataSrc,
//                ALUSrcA, ALUSrcB,
//                WrRegDSrc, RegDst,
//                PCSrc, ALUOp       - datapath selects
//                state              - current FSM state (debug)
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_unit #(
    parameter int ALUOP_W     = 3,
    parameter int MEM_WAIT_EN = 1
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic [5:0]         op,
    input  logic [5:0]         func,
    input  logic               zero,
    input  logic               sign,
    input  logic               mem_ready,
    output logic               PCWre,
    output logic               IRWre,
    output logic               RegWre,
    output logic               ExtSel,
    output logic               DBDataSrc,
    output logic               ALUSrcA,
    output logic               ALUSrcB,
    output logic               mRD,
    output logic               mWR,
    output logic               WrRegDSrc,
    output logic [1:0]         RegDst,
    output logic [1:0]         PCSrc,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [2:0]         state
);

    typedef enum logic [2:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_AL = 3'b110,
        S_EXE_BR = 3'b101,
        S_EXE_LS = 3'b010,
        S_MEM    = 3'b011,
        S_WB_AL  = 3'b111,
        S_WB_LD  = 3'b100
    } stateT;

    localparam logic [5:0] c_opRtype = 6'b000000;
    localparam logic [5:0] c_opAddiu = 6'b001001;
    localparam logic [5:0] c_opAndi  = 6'b001000;
    localparam logic [5:0] c_opOri   = 6'b001101;
    localparam logic [5:0] c_opSlti  = 6'b001010;
    localparam logic [5:0] c_opSw    = 6'b101011;
    localparam logic [5:0] c_opLw    = 6'b100011;
    localparam logic [5:0] c_opBeq   = 6'b110000;
    localparam logic [5:0] c_opBne   = 6'b000101;
    localparam logic [5:0] c_opBltz  = 6'b000001;
    localparam logic [5:0] c_opJ     = 6'b000010;
    localparam logic [5:0] c_opJal   = 6'b000011;
    localparam logic [5:0] c_opHalt  = 6'b111111;

    localparam logic [5:0] c_fnAdd   = 6'b100000;
    localparam logic [5:0] c_fnSub   = 6'b100010;
    localparam logic [5:0] c_fnAnd   = 6'b100100;
    localparam logic [5:0] c_fnOr    = 6'b100101;
    localparam logic [5:0] c_fnSll   = 6'b000000;
    localparam logic [5:0] c_fnJr    = 6'b001000;

    stateT r_state;
    stateT w_nextState;

    // ------------------------------------------------------------------
    // Instruction decode (pure function of the IR fields)
    // ------------------------------------------------------------------
    logic w_isR;
    logic w_isAdd, w_isSub, w_isAnd, w_isOr, w_isSll, w_isJr;
    logic w_isAddiu, w_isAndi, w_isOri, w_isSlti;
    logic w_isSw, w_isLw, w_isBeq, w_isBne, w_isBltz;
    logic w_isJ, w_isJal, w_isHalt;
    logic w_isAluClass, w_isBrClass, w_isLsClass;
    logic w_brTaken, w_memDone;
    logic [2:0] w_aluCode;

    assign w_isR     = (op == c_opRtype);
    assign w_isAdd   = w_isR && (func == c_fnAdd);
    assign w_isSub   = w_isR && (func == c_fnSub);
    assign w_isAnd   = w_isR && (func == c_fnAnd);
    assign w_isOr    = w_isR && (func == c_fnOr);
    assign w_isSll   = w_isR && (func == c_fnSll);
    assign w_isJr    = w_isR && (func == c_fnJr);
    assign w_isAddiu = (op == c_opAddiu);
    assign w_isAndi  = (op == c_opAndi);
    assign w_isOri   = (op == c_opOri);
    assign w_isSlti  = (op == c_opSlti);
    assign w_isSw    = (op == c_opSw);
    assign w_isLw    = (op == c_opLw);
    assign w_isBeq   = (op == c_opBeq);
    assign w_isBne   = (op == c_opBne);
    assign w_isBltz  = (op == c_opBltz);
    assign w_isJ     = (op == c_opJ);
    assign w_isJal   = (op == c_opJal);
    assign w_isHalt  = (op == c_opHalt);

    assign w_isAluClass = w_isAdd | w_isSub | w_isAnd | w_isOr | w_isSll |
                          w_isAddiu | w_isAndi | w_isOri | w_isSlti;
    assign w_isBrClass  = w_isBeq | w_isBne | w_isBltz;
    assign w_isLsClass  = w_isLw | w_isSw;

    assign w_brTaken = (w_isBeq & zero) | (w_isBne & ~zero) | (w_isBltz & sign);

    // With waiting disabled the memory is treated as single-cycle.
    assign w_memDone = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;

    always_comb begin
        w_aluCode = 3'b111;
        if (w_isAdd | w_isAddiu | w_isLw | w_isSw)
            w_aluCode = 3'b000;
        else if (w_isSub | w_isBrClass)
            w_aluCode = 3'b001;
        else if (w_isSll)
            w_aluCode = 3'b010;
        else if (w_isOr | w_isOri)
            w_aluCode = 3'b011;
        else if (w_isAnd | w_isAndi)
            w_aluCode = 3'b100;
        else if (w_isSlti)
            w_aluCode = 3'b110;
    end

    // Decode-only selects: stable for as long as the IR holds.
    assign ALUOp     = ALUOP_W'(w_aluCode);
    assign ALUSrcA   = w_isSll;
    assign ALUSrcB   = w_isAddiu | w_isAndi | w_isOri | w_isSlti | w_isLsClass;
    assign ExtSel    = ~(w_isAndi | w_isOri);
    assign DBDataSrc = w_isLw;
    assign WrRegDSrc = ~w_isJal;
    assign RegDst    = w_isJal ? 2'b10 : (w_isR ? 2'b01 : 2'b00);
    assign state     = r_state;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (Reset)
            r_state <= S_IF;
        else
            r_state <= w_nextState;
    end

    // ------------------------------------------------------------------
    // Next state and state-dependent strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_nextState = S_IF;
        PCWre       = 1'b0;
        IRWre       = 1'b0;
        RegWre      = 1'b0;
        mRD         = 1'b0;
        mWR         = 1'b0;
        PCSrc       = 2'b00;

        case (r_state)
            S_IF: begin
                w_nextState = S_ID;
                IRWre       = 1'b1;
            end
            S_ID: begin
                if (w_isHalt) begin
                    // Parked here until Reset; PC is frozen.
                    w_nextState = S_ID;
                end else if (w_isAluClass) begin
                    w_nextState = S_EXE_AL;
                end else if (w_isBrClass) begin
                    w_nextState = S_EXE_BR;
                end else if (w_isLsClass) begin
                    w_nextState = S_EXE_LS;
                end else begin
                    // j, jal, jr and undefined opcodes retire in decode.
                    w_nextState = S_IF;
                    PCWre       = 1'b1;
                    RegWre      = w_isJal;
                end
            end
            S_EXE_AL: w_nextState = S_WB_AL;
            S_EXE_BR: begin
                w_nextState = S_IF;
                PCWre       = 1'b1;
            end
            S_EXE_LS: w_nextState = S_MEM;
            S_MEM: begin
                mRD = w_isLw;
                mWR = w_isSw;
                if (w_memDone) begin
                    w_nextState = w_isLw ? S_WB_LD : S_IF;
                    // A store retires here, so only it advances the PC.
                    PCWre       = w_isSw;
                end else begin
                    w_nextState = S_MEM;
                end
            end
            S_WB_AL: begin
                w_nextState = S_IF;
                PCWre       = 1'b1;
                RegWre      = 1'b1;
            end
            S_WB_LD: begin
                w_nextState = S_IF;
                PCWre       = 1'b1;
                RegWre      = 1'b1;
            end
            default: w_nextState = S_IF;
        endcase

        if (w_isJ | w_isJal)
            PCSrc = 2'b11;
        else if (w_isJr)
            PCSrc = 2'b10;
        else if ((r_state == S_EXE_BR) && w_brTaken)
            PCSrc = 2'b01;

        // Reset aborts the instruction: no architectural side effects
        // may leak out while it is held, whatever state we are in.
        if (Reset) begin
            PCWre  = 1'b0;
            IRWre  = 1'b0;
            RegWre = 1'b0;
            mRD    = 1'b0;
            mWR    = 1'b0;
            PCSrc  = 2'b00;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_control_unit
//  Description : Self-checking bench for multicycle_control_unit. A model
//                describes each instruction as a path of stages and derives
//                every output from the instruction's attributes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_unit;

    localparam logic [2:0] S_IF = 3'b000, S_ID = 3'b001, S_AL = 3'b110,
                           S_BR = 3'b101, S_LS = 3'b010, S_MEM = 3'b011,
                           S_WBAL = 3'b111, S_WBLD = 3'b100;

    localparam int C_ALU = 0, C_BR = 1, C_LW = 2, C_SW = 3, C_JMP = 4, C_HALT = 5;

    localparam int I_ADD = 0, I_SUB = 1, I_AND = 2, I_OR = 3, I_SLL = 4,
                   I_JR = 5, I_ADDIU = 6, I_ANDI = 7, I_ORI = 8, I_SLTI = 9,
                   I_SW = 10, I_LW = 11, I_BEQ = 12, I_BNE = 13, I_BLTZ = 14,
                   I_J = 15, I_JAL = 16, I_HALT = 17, I_UNDR = 18, I_UNDO = 19;
    localparam int N_INST = 20;

    logic       CLK, Reset, zero, sign, mem_ready;
    logic [5:0] op, func;
    logic       PCWre, IRWre, RegWre, ExtSel, DBDataSrc, ALUSrcA, ALUSrcB;
    logic       mRD, mWR, WrRegDSrc;
    logic [1:0] RegDst, PCSrc;
    logic [2:0] ALUOp, state;

    multicycle_control_unit #(.ALUOP_W(3), .MEM_WAIT_EN(1)) dut (
        .CLK(CLK), .Reset(Reset), .op(op), .func(func), .zero(zero),
        .sign(sign), .mem_ready(mem_ready), .PCWre(PCWre), .IRWre(IRWre),
        .RegWre(RegWre), .ExtSel(ExtSel), .DBDataSrc(DBDataSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .mRD(mRD), .mWR(mWR),
        .WrRegDSrc(WrRegDSrc), .RegDst(RegDst), .PCSrc(PCSrc),
        .ALUOp(ALUOp), .state(state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // pk: 0 none, 1 beq, 2 bne, 3 bltz, 4 j/jal target, 5 jr
    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        int         cls;
        logic [2:0] alu;
        logic       a, b, ext, db;
        logic [1:0] rd;
        logic       wr;
        int         pk;
    } instT;

    instT tbl [N_INST];

    int nVec = 0;
    int nMis = 0;
    int curIdx = I_ADD;
    int nextIdx = I_ADD;
    int mPos = 0;
    bit mValid = 1'b0;
    int haltCnt = 0;

    task automatic setE(input int i, input logic [5:0] o, input logic [5:0] f,
                        input int c, input logic [2:0] al, input logic a,
                        input logic b, input logic e, input logic d,
                        input logic [1:0] r, input logic w, input int p);
        tbl[i].op = o; tbl[i].fn = f; tbl[i].cls = c; tbl[i].alu = al;
        tbl[i].a = a; tbl[i].b = b; tbl[i].ext = e; tbl[i].db = d;
        tbl[i].rd = r; tbl[i].wr = w; tbl[i].pk = p;
    endtask

    function automatic int pathLen(input int c);
        case (c)
            C_ALU:   return 4;
            C_BR:    return 3;
            C_LW:    return 5;
            C_SW:    return 4;
            default: return 2;
        endcase
    endfunction

    function automatic logic [2:0] pathStage(input int c, input int p);
        case (p)
            0:       return S_IF;
            1:       return S_ID;
            2:       return (c == C_ALU) ? S_AL : ((c == C_BR) ? S_BR : S_LS);
            3:       return (c == C_ALU) ? S_WBAL : S_MEM;
            default: return S_WBLD;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got %0h expected %0h at t=%0t (inst %0d pos %0d)",
                     nm, act, exp, $time, curIdx, mPos);
        end
    endtask

    // Advance the model on the active edge using the inputs that were
    // present at that edge.
    task automatic modelUpdate();
        logic [2:0] st;
        if (Reset) begin
            mPos   = 0;
            mValid = 1'b1;
        end else if (mValid) begin
            st = pathStage(tbl[curIdx].cls, mPos);
            if (tbl[curIdx].cls == C_HALT && mPos == 1)
                mPos = 1;
            else if (st == S_MEM && !mem_ready)
                mPos = mPos;
            else if (mPos == pathLen(tbl[curIdx].cls) - 1)
                mPos = 0;
            else
                mPos = mPos + 1;
        end
    endtask

    task automatic step(input bit rstV, input bit rdyV, input bit zV, input bit sV);
        @(posedge CLK);
        modelUpdate();
        #2;
        Reset     = rstV;
        mem_ready = rdyV;
        zero      = zV;
        sign      = sV;
        if (mPos == 0) begin
            curIdx = nextIdx;
            op     = tbl[curIdx].op;
            func   = (tbl[curIdx].op == 6'b000000) ? tbl[curIdx].fn : 6'($urandom);
        end
        if (tbl[curIdx].cls == C_HALT && mPos == 1)
            haltCnt++;
        else
            haltCnt = 0;
    endtask

    // One compare per cycle, mid-period, against the model.
    always @(negedge CLK) begin : b_cmp
        logic [2:0] st;
        logic       last, ePC, eIR, eRW, eRD, eWR;
        logic [1:0] ePCS;
        int         c, pk;
        if (mValid) begin
            c    = tbl[curIdx].cls;
            pk   = tbl[curIdx].pk;
            st   = pathStage(c, mPos);
            last = (mPos == pathLen(c) - 1);
            ePC  = last && (c != C_HALT) && (st != S_MEM || mem_ready);
            eIR  = (st == S_IF);
            eRW  = (st == S_WBAL) || (st == S_WBLD) || (st == S_ID && curIdx == I_JAL);
            eRD  = (st == S_MEM) && (c == C_LW);
            eWR  = (st == S_MEM) && (c == C_SW);
            ePCS = 2'b00;
            if (pk == 4)
                ePCS = 2'b11;
            else if (pk == 5)
                ePCS = 2'b10;
            else if (st == S_BR && ((pk == 1 && zero) || (pk == 2 && !zero) || (pk == 3 && sign)))
                ePCS = 2'b01;
            if (Reset) begin
                ePC = 0; eIR = 0; eRW = 0; eRD = 0; eWR = 0; ePCS = 2'b00;
            end
            chk("state",     {5'b0, state},     {5'b0, st});
            chk("PCWre",     {7'b0, PCWre},     {7'b0, ePC});
            chk("IRWre",     {7'b0, IRWre},     {7'b0, eIR});
            chk("RegWre",    {7'b0, RegWre},    {7'b0, eRW});
            chk("mRD",       {7'b0, mRD},       {7'b0, eRD});
            chk("mWR",       {7'b0, mWR},       {7'b0, eWR});
            chk("PCSrc",     {6'b0, PCSrc},     {6'b0, ePCS});
            chk("ALUOp",     {5'b0, ALUOp},     {5'b0, tbl[curIdx].alu});
            chk("ALUSrcA",   {7'b0, ALUSrcA},   {7'b0, tbl[curIdx].a});
            chk("ALUSrcB",   {7'b0, ALUSrcB},   {7'b0, tbl[curIdx].b});
            chk("ExtSel",    {7'b0, ExtSel},    {7'b0, tbl[curIdx].ext});
            chk("DBDataSrc", {7'b0, DBDataSrc}, {7'b0, tbl[curIdx].db});
            chk("RegDst",    {6'b0, RegDst},    {6'b0, tbl[curIdx].rd});
            chk("WrRegDSrc", {7'b0, WrRegDSrc}, {7'b0, tbl[curIdx].wr});
        end
    end

    initial begin
        //     idx      op         func       cls     alu    A  B  Ext DB RegDst W  pk
        setE(I_ADD,   6'o00, 6'b100000, C_ALU,  3'b000, 0, 0, 1, 0, 2'b01, 1, 0);
        setE(I_SUB,   6'o00, 6'b100010, C_ALU,  3'b001, 0, 0, 1, 0, 2'b01, 1, 0);
        setE(I_AND,   6'o00, 6'b100100, C_ALU,  3'b100, 0, 0, 1, 0, 2'b01, 1, 0);
        setE(I_OR,    6'o00, 6'b100101, C_ALU,  3'b011, 0, 0, 1, 0, 2'b01, 1, 0);
        setE(I_SLL,   6'o00, 6'b000000, C_ALU,  3'b010, 1, 0, 1, 0, 2'b01, 1, 0);
        setE(I_JR,    6'o00, 6'b001000, C_JMP,  3'b111, 0, 0, 1, 0, 2'b01, 1, 5);
        setE(I_ADDIU, 6'b001001, 6'b0,  C_ALU,  3'b000, 0, 1, 1, 0, 2'b00, 1, 0);
        setE(I_ANDI,  6'b001000, 6'b0,  C_ALU,  3'b100, 0, 1, 0, 0, 2'b00, 1, 0);
        setE(I_ORI,   6'b001101, 6'b0,  C_ALU,  3'b011, 0, 1, 0, 0, 2'b00, 1, 0);
        setE(I_SLTI,  6'b001010, 6'b0,  C_ALU,  3'b110, 0, 1, 1, 0, 2'b00, 1, 0);
        setE(I_SW,    6'b101011, 6'b0,  C_SW,   3'b000, 0, 1, 1, 0, 2'b00, 1, 0);
        setE(I_LW,    6'b100011, 6'b0,  C_LW,   3'b000, 0, 1, 1, 1, 2'b00, 1, 0);
        setE(I_BEQ,   6'b110000, 6'b0,  C_BR,   3'b001, 0, 0, 1, 0, 2'b00, 1, 1);
        setE(I_BNE,   6'b000101, 6'b0,  C_BR,   3'b001, 0, 0, 1, 0, 2'b00, 1, 2);
        setE(I_BLTZ,  6'b000001, 6'b0,  C_BR,   3'b001, 0, 0, 1, 0, 2'b00, 1, 3);
        setE(I_J,     6'b000010, 6'b0,  C_JMP,  3'b111, 0, 0, 1, 0, 2'b00, 1, 4);
        setE(I_JAL,   6'b000011, 6'b0,  C_JMP,  3'b111, 0, 0, 1, 0, 2'b10, 0, 4);
        setE(I_HALT,  6'b111111, 6'b0,  C_HALT, 3'b111, 0, 0, 1, 0, 2'b00, 1, 0);
        setE(I_UNDR,  6'o00, 6'b100111, C_JMP,  3'b111, 0, 0, 1, 0, 2'b01, 1, 0);
        setE(I_UNDO,  6'b000100, 6'b0,  C_JMP,  3'b111, 0, 0, 1, 0, 2'b00, 1, 0);

        Reset = 1'b1; mem_ready = 1'b0; zero = 1'b0; sign = 1'b0;
        op = tbl[I_ADD].op; func = tbl[I_ADD].fn;

        // ---- Hand-computed literal checks ----
        nextIdx = I_ADD;
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        #1 chk("lit rst IRWre", {7'b0, IRWre}, 8'h0);
        chk("lit rst PCWre", {7'b0, PCWre}, 8'h0);
        step(0, 0, 0, 0);
        #1 chk("lit add s0", {5'b0, state}, 8'h0);
        chk("lit add IRWre", {7'b0, IRWre}, 8'h1);
        step(0, 0, 0, 0);
        #1 chk("lit add s1", {5'b0, state}, 8'h1);
        step(0, 0, 0, 0);
        #1 chk("lit add s6", {5'b0, state}, 8'h6);
        chk("lit add ALUOp", {5'b0, ALUOp}, 8'h0);
        chk("lit add RegWre6", {7'b0, RegWre}, 8'h0);
        nextIdx = I_LW;
        step(0, 0, 0, 0);
        #1 chk("lit add s7", {5'b0, state}, 8'h7);
        chk("lit add RegWre", {7'b0, RegWre}, 8'h1);
        chk("lit add PCWre", {7'b0, PCWre}, 8'h1);
        chk("lit add RegDst", {6'b0, RegDst}, 8'h1);
        step(0, 0, 0, 0);
        #1 chk("lit add end s0", {5'b0, state}, 8'h0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 0);
            #1 chk("lit lw wait s3", {5'b0, state}, 8'h3);
            chk("lit lw wait mRD", {7'b0, mRD}, 8'h1);
        end
        step(0, 1, 0, 0);
        #1 chk("lit lw ready s3", {5'b0, state}, 8'h3);
        chk("lit lw ready mRD", {7'b0, mRD}, 8'h1);
        nextIdx = I_BEQ;
        step(0, 0, 0, 0);
        #1 chk("lit lw s4", {5'b0, state}, 8'h4);
        chk("lit lw RegWre", {7'b0, RegWre}, 8'h1);
        chk("lit lw DBDataSrc", {7'b0, DBDataSrc}, 8'h1);
        chk("lit lw PCWre", {7'b0, PCWre}, 8'h1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        #1 chk("lit beq z1 PCSrc", {6'b0, PCSrc}, 8'h1);
        chk("lit beq z1 PCWre", {7'b0, PCWre}, 8'h1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        nextIdx = I_BLTZ;
        step(0, 0, 0, 0);
        #1 chk("lit beq z0 PCSrc", {6'b0, PCSrc}, 8'h0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        nextIdx = I_JAL;
        step(0, 0, 0, 1);
        #1 chk("lit bltz PCSrc", {6'b0, PCSrc}, 8'h1);
        step(0, 0, 0, 0);
        nextIdx = I_JR;
        step(0, 0, 0, 0);
        #1 chk("lit jal PCSrc", {6'b0, PCSrc}, 8'h3);
        chk("lit jal RegWre", {7'b0, RegWre}, 8'h1);
        chk("lit jal RegDst", {6'b0, RegDst}, 8'h2);
        chk("lit jal WrRegDSrc", {7'b0, WrRegDSrc}, 8'h0);
        chk("lit jal PCWre", {7'b0, PCWre}, 8'h1);
        step(0, 0, 0, 0);
        #1 chk("lit jal next s0", {5'b0, state}, 8'h0);
        nextIdx = I_HALT;
        step(0, 0, 0, 0);
        #1 chk("lit jr PCSrc", {6'b0, PCSrc}, 8'h2);
        chk("lit jr RegWre", {7'b0, RegWre}, 8'h0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int k = 0; k < 20; k++) begin
            step(0, (k % 2) == 1, (k % 3) == 0, 1'b1);
            #1 chk("lit halt s1", {5'b0, state}, 8'h1);
            chk("lit halt PCWre", {7'b0, PCWre}, 8'h0);
            chk("lit halt RegWre", {7'b0, RegWre}, 8'h0);
            chk("lit halt mWR", {7'b0, mWR}, 8'h0);
        end
        nextIdx = I_SW;
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        #1 chk("lit halt rst s0", {5'b0, state}, 8'h0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        #1 chk("lit sw mem s3", {5'b0, state}, 8'h3);
        chk("lit sw mWR", {7'b0, mWR}, 8'h1);
        step(1, 0, 0, 0);
        #1 chk("lit sw rst mWR", {7'b0, mWR}, 8'h0);
        chk("lit sw rst PCWre", {7'b0, PCWre}, 8'h0);
        step(0, 0, 0, 0);
        #1 chk("lit sw abort s0", {5'b0, state}, 8'h0);
        chk("lit sw abort mWR", {7'b0, mWR}, 8'h0);
        chk("lit sw abort PCWre", {7'b0, PCWre}, 8'h0);

        // ---- Randomized stream ----
        for (int n = 0; n < 4000; n++) begin
            int idx;
            idx = int'($urandom_range(0, N_INST - 1));
            if (idx == I_HALT && ($urandom % 4) != 0)
                idx = I_ADDIU;
            nextIdx = idx;
            step((($urandom % 60) == 0) || (haltCnt > 25),
                 ($urandom % 3) == 0, ($urandom % 2) == 1, ($urandom % 2) == 1);
        end
        step(0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
`default_nettype wire
